// File: rtl/neopix_tx.sv
// WS2812 serial transmitter: an AW-deep byte FIFO feeding a HIGH/LOW bit-timing FSM with LATCH reset gaps.
// Latency: a byte strobed at edge N into an empty FIFO while idle drives do_out high from edge N+2.
// Backpressure: none upstream. A byte that arrives with the FIFO full and no pop is dropped and sets sticky overflow.
// Optional macro NEOPIX_OUT_INVERT_EN complements the pin, including its reset and idle level, for inverting level shifters.
module neopix_tx #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 63,
    parameter int TRST = 2500,
    parameter int AW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_end,
    output logic       do_out,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

`ifdef NEOPIX_OUT_INVERT_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    localparam int CW = $clog2(((TRST > TBIT) ? TRST : TBIT) + 1);
    localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
    localparam logic [CW-1:0] L0_END   = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] L1_END   = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] TRST_END = CW'(TRST - 1);

    // Byte FIFO: the pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [2**AW];
    logic        full;
    logic        empty;
    logic        wr_en;
    logic        pop;
    logic [7:0]  rd_dat;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign wr_en  = rx_valid && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)   rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nxt;
    logic          latch_pend;
    logic          latch_clr;
    logic [CW-1:0] hi_end;
    logic [CW-1:0] lo_end;

    assign hi_end = shreg[7] ? T1H_END : T0H_END;
    assign lo_end = shreg[7] ? L1_END  : L0_END;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        shreg_nxt = shreg;
        bit_nxt   = bit_idx;
        pop       = 1'b0;
        latch_clr = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_nxt = rd_dat;
                    bit_nxt   = 3'd0;
                    state_nxt = HIGH;
                end else if (latch_pend) begin
                    latch_clr = 1'b1;
                    state_nxt = LATCH;
                end
            end
            HIGH: begin
                if (cnt == hi_end) begin
                    cnt_nxt   = '0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (cnt == lo_end) begin
                    cnt_nxt = '0;
                    if (bit_idx != 3'd7) begin
                        shreg_nxt = {shreg[6:0], 1'b0};
                        bit_nxt   = bit_idx + 3'd1;
                        state_nxt = HIGH;
                    end else if (!empty) begin
                        // Reload straight from the FIFO so consecutive bytes leave no gap.
                        pop       = 1'b1;
                        shreg_nxt = rd_dat;
                        bit_nxt   = 3'd0;
                        state_nxt = HIGH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            LATCH: begin
                if (cnt == TRST_END) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // The pending flag drops when LATCH is entered, so a frame_end seen during LATCH queues one more latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            latch_pend <= 1'b0;
            overflow   <= 1'b0;
            do_out     <= OUT_INV;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_nxt;
            if (frame_end)      latch_pend <= 1'b1;
            else if (latch_clr) latch_pend <= 1'b0;
            if (rx_valid && full && !pop) overflow <= 1'b1;
            do_out <= (state == HIGH) ^ OUT_INV;
        end
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_neopix_tx.sv
// Directed bench for neopix_tx: a table of byte/frame vectors, plus hand sequences for overflow, latch and reset.
module tb_neopix_tx;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int TBIT = 63;

`ifdef NEOPIX_OUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_end = 1'b0;
    logic       do_out;
    logic       busy;
    logic       overflow;

    neopix_tx dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_end(frame_end),
        .do_out   (do_out),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The waveform is measured with any inversion removed, so one set of expectations serves both builds.
    wire  line = do_out ^ INV;
    logic prev_line = 1'b0;
    int   rises[$];
    int   falls[$];
    always @(negedge clk) begin
        if (line && !prev_line) rises.push_back(cyc);
        if (!line && prev_line) falls.push_back(cyc);
        prev_line <= line;
    end

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rises.delete();
        falls.delete();
        exp_q.delete();
    endtask

    // Called at a falling edge; returns at the next falling edge with sc = index of the capturing rising edge.
    task automatic strobe(input logic [7:0] d, output int sc);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 sc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_fe(output int fc);
        frame_end = 1'b1;
        @(posedge clk);
        #1 fc = cyc;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    // busy dips for one cycle in the IDLE bubble before a LATCH, so idle means low on two falling edges in a row.
    task automatic wait_idle(output int done);
        int n = 0;
        int lows = 0;
        done = -1;
        @(posedge clk);
        while (n < 12000) begin
            @(negedge clk);
            n++;
            if (!busy) begin
                lows++;
                if (lows == 2) begin
                    done = cyc - 1;
                    break;
                end
            end else begin
                lows = 0;
            end
        end
        if (done < 0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still high after %0d cycles, expected low", n);
        end
    endtask

    task automatic check_stream(input string name, input int sc, input int gap_idx);
        int nb = exp_q.size() * 8;
        chk({name, " rises"}, rises.size(), nb);
        chk({name, " falls"}, falls.size(), nb);
        if (rises.size() == nb && falls.size() == nb && nb > 0) begin
            chk({name, " latency"}, rises[0] - sc, 2);
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                b = exp_q[i / 8];
                chk($sformatf("%s high%0d", name, i), falls[i] - rises[i], b[7 - (i % 8)] ? T1H : T0H);
                if (i > 0 && i != gap_idx)
                    chk($sformatf("%s period%0d", name, i), rises[i] - rises[i - 1], TBIT);
            end
        end
    endtask

    function automatic int first_rise();
        return (rises.size() > 0) ? rises[0] : -100000;
    endfunction

    typedef struct packed {
        logic [1:0]  n;
        logic [23:0] dat;
        logic        fe;
        logic [15:0] done_ofs;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int s;
        int fc;
        int f2;
        int done;
        logic [7:0] b;

        // done_ofs is the cycle distance from the first rising edge to busy settling low.
        vecs[0] = '{2'd1, 24'hAA0000, 1'b0, 16'd503};
        vecs[1] = '{2'd1, 24'h000000, 1'b0, 16'd503};
        vecs[2] = '{2'd1, 24'hFF0000, 1'b0, 16'd503};
        vecs[3] = '{2'd1, 24'hAA0000, 1'b1, 16'd3004};
        vecs[4] = '{2'd3, 24'h0055AA, 1'b0, 16'd1511};
        vecs[5] = '{2'd1, 24'h810000, 1'b0, 16'd503};
        vecs[6] = '{2'd2, 24'hC35A00, 1'b1, 16'd3508};

        #1;
        chk("reset do_out", do_out, INV);
        chk("reset busy", busy, 0);
        chk("reset overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            clear_mon();
            sc = 0;
            for (int k = 0; k < vecs[v].n; k++) begin
                b = vecs[v].dat[23 - 8 * k -: 8];
                strobe(b, s);
                if (k == 0) sc = s;
                exp_q.push_back(b);
                if (k < vecs[v].n - 1) @(negedge clk);
            end
            if (vecs[v].fe) pulse_fe(fc);
            wait_idle(done);
            check_stream($sformatf("vec%0d", v), sc, -1);
            chk($sformatf("vec%0d done", v), done - first_rise(), vecs[v].done_ofs);
            chk($sformatf("vec%0d overflow", v), overflow, 0);
        end

        // frame_end while idle and empty still produces a full latch; a second one during it adds another.
        @(negedge clk);
        clear_mon();
        pulse_fe(fc);
        wait_idle(done);
        chk("lone latch length", done - fc, 2501);
        chk("lone latch rises", rises.size(), 0);
        @(negedge clk);
        pulse_fe(fc);
        while (cyc < fc + 100) @(negedge clk);
        pulse_fe(f2);
        wait_idle(done);
        chk("double latch length", done - fc, 5002);
        chk("double latch rises", rises.size(), 0);

        // 20 back-to-back strobes: byte 0 is popped at once, 16 more fill the FIFO, the last 3 are dropped.
        @(negedge clk);
        clear_mon();
        for (int k = 0; k < 20; k++) begin
            rx_data  = 8'h11 + 8'(k * 13);
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            if (k == 0) sc = cyc;
            if (k < 17) exp_q.push_back(rx_data);
            if (k == 16) chk("overflow before drop", overflow, 0);
            if (k == 17) chk("overflow on drop", overflow, 1);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        wait_idle(done);
        check_stream("burst", sc, -1);
        chk("burst done", done - first_rise(), 17 * 504 - 1);
        chk("overflow sticky", overflow, 1);

        // Latch waits for both queued bytes; a byte arriving mid-latch follows it.
        @(negedge clk);
        clear_mon();
        strobe(8'h12, sc);
        exp_q.push_back(8'h12);
        @(negedge clk);
        strobe(8'h34, s);
        exp_q.push_back(8'h34);
        pulse_fe(fc);
        while (cyc < sc + 1600) @(negedge clk);
        strobe(8'hFF, s);
        exp_q.push_back(8'hFF);
        wait_idle(done);
        check_stream("latch gap", sc, 16);
        if (rises.size() == 24) chk("latch gap rise15->16", rises[16] - rises[15], 2565);
        chk("latch gap done", done - first_rise(), 4013);

        // Reset during a HIGH phase with a byte still queued.
        @(negedge clk);
        clear_mon();
        strobe(8'hFF, sc);
        strobe(8'h0F, s);
        while (cyc < sc + 12) @(negedge clk);
        chk("line high before rst", line, 1);
        rst = 1'b1;
        #1;
        chk("rst truncates bit", line, 0);
        chk("rst do_out level", do_out, INV);
        chk("rst busy", busy, 0);
        chk("rst overflow", overflow, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst held busy", busy, 0);
        chk("rst held line", line, 0);
        clear_mon();
        rst = 1'b0;
        strobe(8'hAA, sc);
        exp_q.push_back(8'hAA);
        wait_idle(done);
        check_stream("post rst", sc, -1);
        chk("post rst done", done - first_rise(), 503);
        chk("post rst overflow", overflow, 0);
        chk("idle level", do_out, INV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
